// File: rtl/cpu_dma_tx_watchdog.sv
// cpu_dma_tx_watchdog: declares a timeout when a DMA TX packet stalls, then requests a flush
// Ports: clk, reset (sync, active-high), wd_enable, tx_pkt_start, tx_word_vld,
//   tx_pkt_end, flush_ack in; tx_timeout (one-cycle pulse), flush_req (level),
//   wd_busy (ACTIVE or FLUSH) out, all registered.
// Optional: define CPU_DMA_TX_WD_MAX_STALL_EN to add max_stall[31:0], the longest stall seen since reset.
module cpu_dma_tx_watchdog #(
  parameter int unsigned TX_WATCHDOG_TIMEOUT = 125000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wd_enable,
  input  logic        tx_pkt_start,
  input  logic        tx_word_vld,
  input  logic        tx_pkt_end,
  input  logic        flush_ack,
  output logic        tx_timeout,
  output logic        flush_req,
  output logic        wd_busy
`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
  ,
  output logic [31:0] max_stall
`endif
);
  localparam int CW = $clog2(TX_WATCHDOG_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TX_WATCHDOG_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic clr, tmo;
  assign clr = (state == ACTIVE) && (tx_pkt_end || tx_word_vld || tx_pkt_start);
  assign tmo = (state == ACTIVE) && !clr && wd_enable && (cnt == LAST);
  // The counter never passes LAST: the terminal count moves to FLUSH instead of incrementing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_timeout <= 1'b0;
      flush_req  <= 1'b0;
      wd_busy    <= 1'b0;
    end else begin
      tx_timeout <= 1'b0;
      case (state)
        IDLE: if (tx_pkt_start) begin
          state   <= ACTIVE;
          cnt     <= '0;
          wd_busy <= 1'b1;
        end
        ACTIVE: if (tx_pkt_end) begin
          state   <= IDLE;
          cnt     <= '0;
          wd_busy <= 1'b0;
        end else if (tx_word_vld || tx_pkt_start) begin
          cnt <= '0;
        end else if (tmo) begin
          state      <= FLUSH;
          tx_timeout <= 1'b1;
          flush_req  <= 1'b1;
        end else if (wd_enable) begin
          cnt <= cnt + CW'(1);
        end
        FLUSH: if (flush_ack) begin
          state     <= IDLE;
          cnt       <= '0;
          flush_req <= 1'b0;
          wd_busy   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          flush_req <= 1'b0;
          wd_busy   <= 1'b0;
        end
      endcase
    end
  end
`ifdef CPU_DMA_TX_WD_MAX_STALL_EN
  // Sampled only when a stall ends (cnt cleared) or times out; a timeout reports the full timeout length.
  always_ff @(posedge clk) begin
    if (reset) max_stall <= '0;
    else if (tmo) max_stall <= TX_WATCHDOG_TIMEOUT;
    else if (clr && 32'(cnt) > max_stall) max_stall <= 32'(cnt);
  end
`endif
endmodule
